// File: rtl/sub64_serial.sv
// Multi-cycle 64-bit subtractor: diff = a + ~b + 1, one SLICE-bit chunk per clock.
// Produces Y-86 condition flags (OF, ZF, SF, borrow) behind a start/busy/done handshake.
module sub64_serial #(
    parameter int SLICE = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] diff,
    output logic        of,
    output logic        zf,
    output logic        sf,
    output logic        bf,
    output logic        busy,
    output logic        done
);

    localparam int N  = 64 / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [63:0]    a_q;
    logic [63:0]    nb_q;
    logic [KW-1:0]  k;
    logic           carry;

    logic           accept;
    logic           last;
    logic [6:0]     base;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] nb_sl;
    logic [SLICE-1:0] sum_sl;
    logic           cout;
    logic [63:0]    diff_next;

    // Operands are accepted whenever the unit is not in RUN, which allows back-to-back issue from DONE.
    assign accept = start && (state != RUN);
    assign last   = (k == KW'(N - 1));

    always_comb begin
        base      = 7'(k) * 7'(SLICE);
        a_sl      = a_q[base +: SLICE];
        nb_sl     = nb_q[base +: SLICE];
        {cout, sum_sl} = {1'b0, a_sl} + {1'b0, nb_sl} + (SLICE + 1)'(carry);
        diff_next = diff;
        diff_next[base +: SLICE] = sum_sl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy and done decode the state register directly, so they carry no input-to-output path.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            nb_q  <= '0;
            k     <= '0;
            carry <= 1'b0;
            diff  <= '0;
            of    <= 1'b0;
            zf    <= 1'b0;
            sf    <= 1'b0;
            bf    <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            nb_q  <= ~b;
            k     <= '0;
            carry <= 1'b1;
        end else if (state == RUN) begin
            diff  <= diff_next;
            carry <= cout;
            k     <= k + KW'(1);
            if (last) begin
                // a[63] != b[63] is the same as a_q[63] == ~b[63] stored in nb_q.
                bf <= ~cout;
                of <= (a_q[63] == nb_q[63]) && (diff_next[63] != a_q[63]);
                zf <= (diff_next == 64'd0);
                sf <= diff_next[63];
            end
        end
    end

endmodule
